pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake, flush and optional 2-entry skid buffer.

---
 rtl/pipe_stage_skid.sv | 188 ++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional second (skid) entry so in_ready can come straight from a flop.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter bit                SKID        = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_HOLD,
        M_LOAD_IN,
        M_LOAD_SKID,
        M_CLEAR
    } msel_t;

    state_t            state;
    state_t            state_next;
    msel_t             m_sel;
    logic              s_load;
    logic              s_clear;
    logic              accept;
    logic              drain;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // State register: reset and flush both return to the empty state.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_next = SKID ? FULL : ONE;
                end else if (!accept && drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Output / datapath-control logic.
    always_comb begin
        m_sel     = M_HOLD;
        s_load    = 1'b0;
        s_clear   = 1'b0;
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    m_sel = M_LOAD_IN;
                end
            end
            ONE: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
                if (accept && drain) begin
                    m_sel = M_LOAD_IN;
                end else if (accept) begin
                    s_load = SKID;
                end else if (drain) begin
                    m_sel = M_CLEAR;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
                if (drain) begin
                    m_sel   = M_LOAD_SKID;
                    s_clear = 1'b1;
                end
            end
            default: begin
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    // Main (head) and skid registers; an emptied slot reads as a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m_data <= '0;
            m_ctrl <= BUBBLE_CTRL;
            s_data <= '0;
            s_ctrl <= BUBBLE_CTRL;
        end else begin
            case (m_sel)
                M_LOAD_IN: begin
                    m_data <= in_data;
                    m_ctrl <= in_ctrl;
                end
                M_LOAD_SKID: begin
                    m_data <= s_data;
                    m_ctrl <= s_ctrl;
                end
                M_CLEAR: begin
                    m_data <= '0;
                    m_ctrl <= BUBBLE_CTRL;
                end
                default: begin
                    m_data <= m_data;
                    m_ctrl <= m_ctrl;
                end
            endcase
            if (s_load) begin
                s_data <= in_data;
                s_ctrl <= in_ctrl;
            end else if (s_clear) begin
                s_data <= '0;
                s_ctrl <= BUBBLE_CTRL;
            end
        end
    end

    assign out_data = m_data;
    assign out_ctrl = m_ctrl;

    // With the skid entry, in_ready is precomputed from the next state so
    // downstream out_ready never reaches upstream combinationally.
    if (SKID) begin : g_skid_ready
        logic in_ready_q;
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_next != FULL);
            end
        end
        assign in_ready = in_ready_q;
    end else begin : g_comb_ready
        assign in_ready = ~out_valid | out_ready;
    end

    a_occupancy_bound : assert property (@(posedge clk) disable iff (reset)
        occupancy <= (SKID ? 2'd2 : 2'd1));

    a_stall_stable : assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> ($stable(out_data) && $stable(out_ctrl)));

    a_bubble_ctrl : assert property (@(posedge clk) disable iff (reset)
        !out_valid |-> (out_ctrl == BUBBLE_CTRL && out_data == '0));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: SKID=1 and SKID=0 builds driven in parallel and
// compared each cycle against queue-based reference models.
module tb_pipe_stage_skid;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 8;
    localparam logic [7:0]  BUB = 8'hA5;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic [CW-1:0] in_ctrl   = '0;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [1:0]    occ1, occ0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .occupancy(occ1)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .SKID(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .occupancy(occ0)
    );

    // Reference: a bounded FIFO of {data,ctrl}; capacity 2 (skid) or 1.
    logic [39:0] q1[$];
    logic [39:0] q0[$];
    bit a1, d1, a0, d0;

    always @(posedge clk) begin
        if (reset || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            a1 = in_valid && (q1.size() < 2);
            d1 = (q1.size() > 0) && out_ready;
            a0 = in_valid && ((q0.size() == 0) || out_ready);
            d0 = (q0.size() > 0) && out_ready;
            if (d1) void'(q1.pop_front());
            if (a1) q1.push_back({in_data, in_ctrl});
            if (d0) void'(q0.pop_front());
            if (a0) q0.push_back({in_data, in_ctrl});
        end
    end

    // Expected {in_ready, out_valid, out_data, out_ctrl, occupancy}.
    function automatic logic [43:0] exp1();
        logic [39:0] h;
        h = (q1.size() > 0) ? q1[0] : {32'h0, BUB};
        return {(q1.size() < 2), (q1.size() > 0), h, 2'(q1.size())};
    endfunction

    function automatic logic [43:0] exp0();
        logic [39:0] h;
        h = (q0.size() > 0) ? q0[0] : {32'h0, BUB};
        return {((q0.size() == 0) || out_ready), (q0.size() > 0), h, 2'(q0.size())};
    endfunction

    wire [43:0] got1 = {in_ready1, out_valid1, out_data1, out_ctrl1, occ1};
    wire [43:0] got0 = {in_ready0, out_valid0, out_data0, out_ctrl0, occ0};
    wire [43:0] rst_val = {1'b1, 1'b0, 32'h0, BUB, 2'd0};

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_ctrl = 8'h3C; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (got1 !== rst_val) begin errors++; $display("FAIL reset_skid1 got=%h exp=%h", got1, rst_val); end
        checks++;
        if (got0 !== rst_val) begin errors++; $display("FAIL reset_skid0 got=%h exp=%h", got0, rst_val); end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (got1 !== rst_val) begin errors++; $display("FAIL reset_release got=%h exp=%h", got1, rst_val); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'h1000 + 32'(4 * i); in_ctrl = 8'(i + 1);
            @(negedge clk);
            checks++;
            if (got1 !== exp1()) begin errors++; $display("FAIL stream_model1 cyc=%0d got=%h exp=%h", i, got1, exp1()); end
            checks++;
            if (got0 !== exp0()) begin errors++; $display("FAIL stream_model0 cyc=%0d got=%h exp=%h", i, got0, exp0()); end
            if (i > 0) begin
                checks++;
                if ({out_valid1, out_data1, occ1, in_ready1} !== {1'b1, 32'h1000 + 32'(4 * (i - 1)), 2'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL stream_seq cyc=%0d got data=%h occ=%0d rdy=%b exp data=%h occ=1 rdy=1",
                             i, out_data1, occ1, in_ready1, 32'h1000 + 32'(4 * (i - 1)));
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (got1 !== exp1()) begin errors++; $display("FAIL stream_tail got=%h exp=%h", got1, exp1()); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] vals [3];
        logic [31:0] seen [8];
        int          seen_cyc [8];
        int          n;
        vals[0] = 32'hAAAA_0001; vals[1] = 32'hBBBB_0002; vals[2] = 32'hCCCC_0003;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vals[(i < 3) ? i : 2]; in_ctrl = 8'(8'h40 + i);
            if (i == 3) in_ctrl = 8'h42;
            @(negedge clk);
            checks++;
            if (got1 !== exp1()) begin errors++; $display("FAIL fill_model1 cyc=%0d got=%h exp=%h", i, got1, exp1()); end
            if (i == 3) begin
                checks++;
                if ({occ1, in_ready1, out_data1} !== {2'd2, 1'b0, vals[0]}) begin
                    errors++;
                    $display("FAIL fill_full got occ=%0d rdy=%b data=%h exp occ=2 rdy=0 data=%h",
                             occ1, in_ready1, out_data1, vals[0]);
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (got1 !== exp1()) begin errors++; $display("FAIL drain_model1 cyc=%0d got=%h exp=%h", c, got1, exp1()); end
            checks++;
            if (got0 !== exp0()) begin errors++; $display("FAIL drain_model0 cyc=%0d got=%h exp=%h", c, got0, exp0()); end
            if (out_valid1 && n < 8) begin seen[n] = out_data1; seen_cyc[n] = c; n++; end
            if (in_valid && in_ready1) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL drain_count got=%0d exp=3", n);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (seen[k] !== vals[k] || seen_cyc[k] != k) begin
                    errors++;
                    $display("FAIL drain_order idx=%0d got=%h@%0d exp=%h@%0d", k, seen[k], seen_cyc[k], vals[k], k);
                end
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'h5000 + 32'(i); in_ctrl = 8'h60 + 8'(i);
            @(posedge clk); #1;
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hF1F1_F1F1; in_ctrl = 8'h77;
        @(negedge clk);
        checks++;
        if (occ1 !== 2'd2) begin errors++; $display("FAIL flush_prefull got=%0d exp=2", occ1); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (got1 !== rst_val) begin errors++; $display("FAIL flush_state1 got=%h exp=%h", got1, rst_val); end
        checks++;
        if (got0 !== rst_val) begin errors++; $display("FAIL flush_state0 got=%h exp=%h", got0, rst_val); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (out_valid1 !== 1'b0 || got1 !== exp1()) begin
                errors++; $display("FAIL flush_dropped cyc=%0d got=%h exp=%h", i, got1, exp1());
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 100; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            @(negedge clk);
            checks++;
            if (got1 !== exp1()) begin errors++; $display("FAIL random_model1 cyc=%0d got=%h exp=%h", i, got1, exp1()); end
            checks++;
            if (got0 !== exp0()) begin errors++; $display("FAIL random_model0 cyc=%0d got=%h exp=%h", i, got0, exp0()); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h7000 + 32'(i); in_ctrl = 8'h11;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (occ1 !== 2'd2 || occ0 !== 2'd1) begin
            errors++; $display("FAIL midreset_pre got occ1=%0d occ0=%0d exp 2,1", occ1, occ0);
        end
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (got1 !== rst_val) begin errors++; $display("FAIL midreset_state1 got=%h exp=%h", got1, rst_val); end
        checks++;
        if (got0 !== rst_val) begin errors++; $display("FAIL midreset_state0 got=%h exp=%h", got0, rst_val); end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_skid0();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h9000_0001; in_ctrl = 8'h21;
        @(posedge clk); #1;
        in_data = 32'h9000_0002; in_ctrl = 8'h22;
        @(negedge clk);
        checks++;
        if ({in_ready0, occ0, out_data0} !== {1'b0, 2'd1, 32'h9000_0001}) begin
            errors++; $display("FAIL skid0_stall got rdy=%b occ=%0d data=%h exp rdy=0 occ=1 data=90000001",
                               in_ready0, occ0, out_data0);
        end
        #1 out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 1'b1) begin errors++; $display("FAIL skid0_comb_ready got=%b exp=1", in_ready0); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({occ0, out_data0, out_ctrl0} !== {2'd1, 32'h9000_0002, 8'h22}) begin
            errors++; $display("FAIL skid0_replace got occ=%0d data=%h ctrl=%h exp occ=1 data=90000002 ctrl=22",
                               occ0, out_data0, out_ctrl0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 1) == 1;
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            @(negedge clk);
            checks++;
            if (got0 !== exp0() || occ0 > 2'd1) begin
                errors++; $display("FAIL skid0_random cyc=%0d got=%h exp=%h", i, got0, exp0());
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_flush();
        test_random();
        test_reset_mid();
        test_skid0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
